// File: rtl/xy_addr_pkg.sv
// Shared types and helpers for the raster-order pixel address generator.
package xy_addr_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

  // Number of bits needed to represent values 0..n-1 (minimum 1).
  function automatic int unsigned width_for(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((longint'(1) << w) < longint'(n)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/xy_addr_gen_wrap_counter.sv
// Modulo-MAX counter with synchronous clear and a combinational carry on the wrapping increment.
module wrap_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o,
  output logic         carry_o
);

  localparam logic [W-1:0] Last = W'(MAX - 1);

  logic [W-1:0] value_d, value_q;

  assign carry_o = inc_i && (value_q == Last);
  assign value_o = value_q;

  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = '0;
    end else if (inc_i) begin
      value_d = (value_q == Last) ? '0 : value_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/xy_addr_gen.sv
// Raster-order (x fastest) pixel address generator with line/frame strobes.
// Define XY_ADDR_LINEAR_EN to maintain the linear framebuffer address lin_addr.
module xy_addr_gen
  import xy_addr_pkg::*;
#(
  parameter int unsigned X_MAX  = 320,
  parameter int unsigned Y_MAX  = 240,
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 9,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              step,
  input  logic              cont,
  output logic [X_W-1:0]    x_addr,
  output logic [Y_W-1:0]    y_addr,
  output logic [ADDR_W-1:0] lin_addr,
  output logic              busy,
  output logic              line_end,
  output logic              frame_end
);

  if (X_W < width_for(X_MAX)) begin : g_x_w_chk
    $error("X_W too narrow for X_MAX");
  end
  if (Y_W < width_for(Y_MAX)) begin : g_y_w_chk
    $error("Y_W too narrow for Y_MAX");
  end
  if (ADDR_W < width_for(X_MAX * Y_MAX)) begin : g_addr_w_chk
    $error("ADDR_W too narrow for X_MAX*Y_MAX");
  end

  state_e state_d, state_q;
  logic   adv, x_carry, y_carry, frame_wrap;
  logic   line_end_d, line_end_q, frame_end_d, frame_end_q;

  // start wins over step, so a restart never produces strobes.
  assign adv        = (state_q == StScan) && step && !start;
  assign frame_wrap = x_carry && y_carry;

  wrap_counter #(
    .MAX (X_MAX),
    .W   (X_W)
  ) u_x_cnt (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clear_i (start),
    .inc_i   (adv),
    .value_o (x_addr),
    .carry_o (x_carry)
  );

  wrap_counter #(
    .MAX (Y_MAX),
    .W   (Y_W)
  ) u_y_cnt (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clear_i (start),
    .inc_i   (x_carry),
    .value_o (y_addr),
    .carry_o (y_carry)
  );

  always_comb begin
    state_d     = state_q;
    line_end_d  = x_carry;
    frame_end_d = frame_wrap;
    unique case (state_q)
      StIdle:  if (start) state_d = StScan;
      StScan:  if (!start && frame_wrap && !cont) state_d = StDone;
      StDone:  if (start) state_d = StScan;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign busy      = (state_q == StScan);
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;

`ifdef XY_ADDR_LINEAR_EN
  logic [ADDR_W-1:0] lin_d, lin_q;

  always_comb begin
    lin_d = lin_q;
    if (start) begin
      lin_d = '0;
    end else if (adv) begin
      lin_d = frame_wrap ? '0 : lin_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lin_q <= '0;
    end else begin
      lin_q <= lin_d;
    end
  end

  assign lin_addr = lin_q;
`else
  assign lin_addr = '0;
`endif

endmodule

// File: tb/tb_xy_addr_gen.sv
// Scoreboard bench for xy_addr_gen: a pixel-index model feeds a queue, a monitor compares.
module tb_xy_addr_gen;

  localparam int XM = 4;
  localparam int YM = 3;
  localparam int XW = 3;
  localparam int YW = 2;
  localparam int AW = 4;
  localparam int NPIX = XM * YM;

  typedef struct {
    int x;
    int y;
    int lin;
    bit busy;
    bit le;
    bit fe;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          cont = 1'b0;
  logic [XW-1:0] x_addr;
  logic [YW-1:0] y_addr;
  logic [AW-1:0] lin_addr;
  logic          busy, line_end, frame_end;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  // Model: pixel index p within the frame, mode 0=idle 1=scanning 2=finished.
  int   p = 0;
  int   mode = 0;

  xy_addr_gen #(
    .X_MAX  (XM),
    .Y_MAX  (YM),
    .X_W    (XW),
    .Y_W    (YW),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .step      (step),
    .cont      (cont),
    .x_addr    (x_addr),
    .y_addr    (y_addr),
    .lin_addr  (lin_addr),
    .busy      (busy),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  always #5 clk = ~clk;

  function automatic exp_t snapshot(input bit le, input bit fe);
    exp_t e;
    e.x    = p % XM;
    e.y    = p / XM;
`ifdef XY_ADDR_LINEAR_EN
    e.lin  = p;
`else
    e.lin  = 0;
`endif
    e.busy = (mode == 1);
    e.le   = le;
    e.fe   = fe;
    return e;
  endfunction

  task automatic compare(input exp_t e, input string name);
    n_vec++;
    if (int'(x_addr) != e.x || int'(y_addr) != e.y || int'(lin_addr) != e.lin ||
        busy != e.busy || line_end != e.le || frame_end != e.fe) begin
      n_err++;
      $display("FAIL %s @%0t: got x=%0d y=%0d lin=%0d busy=%0b le=%0b fe=%0b, want x=%0d y=%0d lin=%0d busy=%0b le=%0b fe=%0b",
               name, $time, x_addr, y_addr, lin_addr, busy, line_end, frame_end,
               e.x, e.y, e.lin, e.busy, e.le, e.fe);
    end
  endtask

  task automatic cycle(input bit s, input bit st, input bit c);
    bit le, fe;
    @(negedge clk);
    start = s;
    step  = st;
    cont  = c;
    le = 1'b0;
    fe = 1'b0;
    if (s) begin
      mode = 1;
      p    = 0;
    end else if (mode == 1 && st) begin
      le = (p % XM == XM - 1);
      if (p == NPIX - 1) begin
        fe = 1'b1;
        p  = 0;
        if (!c) mode = 2;
      end else begin
        p++;
      end
    end
    sb.push_back(snapshot(le, fe));
  endtask

  // Pull reset low between clock edges and check outputs clear without waiting for an edge.
  task automatic async_reset();
    @(negedge clk);
    start = 1'b0;
    step  = 1'b0;
    #2 reset_n = 1'b0;
    p    = 0;
    mode = 0;
    #1 compare(snapshot(1'b0, 1'b0), "async_reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare(e, "scoreboard");
      end
    end
  end

  initial begin : driver
    #3 reset_n = 1'b0;
    #1 compare(snapshot(1'b0, 1'b0), "reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    // Single-shot frame, then stepping in DONE must not move anything.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NPIX; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);

    // Two continuous frames.
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2 * NPIX; i++) cycle(1'b0, 1'b1, 1'b1);

    // Restart at (2,1) coinciding with a step.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < XM + 2; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);

    // Reset at (3,1), then steps in IDLE are ignored.
    for (int i = 0; i < XM + 3; i++) cycle(1'b0, 1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 85,
              $urandom_range(0, 99) < 60);
      end
    end

    @(negedge clk);
    start = 1'b0;
    step  = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xy_addr_gen.md
# xy_addr_gen

Parametrised two-dimensional pixel address generator for the Pong display path; successor to the single-axis X address counter. Walks a frame in raster order (x fastest, then y), one pixel per accepted step, with line-end and frame-end strobes, single-shot or continuous scanning, and an optional linear framebuffer address. Sits between the video timing logic and the framebuffer/sprite lookup.

## Interface
- X_MAX, 320, pixels per line; x runs 0..X_MAX-1 (X_MAX ≥ 2)
- Y_MAX, 240, lines per frame; y runs 0..Y_MAX-1 (Y_MAX ≥ 2)
- X_W, 10, x_addr width, must hold X_MAX-1
- Y_W, 9, y_addr width, must hold Y_MAX-1
- ADDR_W, 17, lin_addr width, must hold X_MAX*Y_MAX-1

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin/restart a frame at (0,0)
- step  in  1  advance one pixel (ignored unless scanning)
- cont  in  1  1 = continuous: wrap to (0,0) after last pixel and keep scanning; sampled at each frame end
- x_addr  out  X_W  current column
- y_addr  out  Y_W  current row
- lin_addr  out  ADDR_W  y*X_MAX+x (only with XY_ADDR_LINEAR_EN; tied 0 otherwise)
- busy  out  1  high in SCAN
- line_end  out  1  one-cycle strobe: a line just completed
- frame_end  out  1  one-cycle strobe: a frame just completed

## Operation
- States: IDLE, SCAN, DONE. Reset → IDLE.
- IDLE: start → SCAN, x=y=0. step ignored.
- SCAN, step=1: x<X_MAX-1 → x+1. x=X_MAX-1 → x=0, line_end=1, y+1 unless y=Y_MAX-1.
- Last pixel (x=X_MAX-1, y=Y_MAX-1) with step: x=y=0, line_end=1, frame_end=1; cont=1 → stay SCAN, cont=0 → DONE.
- DONE: x=y=0, busy=0; start → SCAN. step ignored.
- start has priority over step in every state: in SCAN it forces (0,0), no strobes, stays SCAN.
- Strobes are never asserted from IDLE/DONE or on a start cycle.
- Counters never exceed MAX-1; no out-of-range value is ever output.

## Timing
- All outputs registered. step/start at edge n → new x_addr/y_addr/lin_addr/strobes/busy visible after edge n, held through cycle n+1.
- Latency 1 cycle; throughput one pixel per cycle with step held high.
- line_end/frame_end high exactly one cycle per qualifying step; back-to-back possible when X_MAX steps elapse.
- Reset values: x_addr=0, y_addr=0, lin_addr=0, busy=0, line_end=0, frame_end=0, state IDLE.
- reset_n low mid-frame clears everything immediately (asynchronous); release requires a fresh start.

## Configuration
- XY_ADDR_LINEAR_EN defined: lin_addr maintained incrementally (+1 per step, 0 on wrap to (0,0) and on start); no multiplier. Always equals y_addr*X_MAX+x_addr.
- Undefined: lin_addr tied to 0, incrementer logic absent; all other behaviour identical.

## Structure
- Package xy_addr_pkg: state enum (IDLE, SCAN, DONE), width helper function (clog2-style) for default width checks.
- Sub-module wrap_counter (parameters MAX, W): clear, inc inputs; value, carry (combinational, inc at MAX-1) outputs; wraps MAX-1→0. Instantiated for x (inc=step in SCAN) and y (inc=x carry).
- Top holds FSM, strobe registers and optional linear counter.

## Test plan
- X_MAX=4, Y_MAX=3, cont=0: reset, start, 12 steps → (x,y) sequence (0,0)…(3,2), line_end after steps 4, 8, 12, frame_end after step 12, state DONE, busy=0, outputs (0,0).
- Same, cont=1, 24 continuous steps → two frame_end pulses (after steps 12 and 24), busy stays 1, sequence repeats.
- Start asserted at (2,1) together with step → next cycle (0,0), no strobes, busy=1.
- reset_n pulsed low at (3,1) asynchronously (between edges) → outputs 0 immediately, IDLE; steps before start leave (0,0).
- step in IDLE and DONE for 5 cycles → no address change, no strobes.
- XY_ADDR_LINEAR_EN defined, default params: 76800 steps → lin_addr equals y*320+x every cycle, 76799 before final step, 0 after.
